// File: rtl/rs_pkg.sv
// rs_pkg: shared sizes and helpers for the reservation-station entry tracker
package rs_pkg;
  localparam int RS_SIZE  = 8;
  localparam int RS_IDX_W = $clog2(RS_SIZE);
  localparam int RS_CNT_W = $clog2(RS_SIZE + 1);
  function automatic logic [RS_CNT_W-1:0] popcount(input logic [RS_SIZE-1:0] v);
    logic [RS_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RS_SIZE; i++) n = n + RS_CNT_W'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rs_entry_tracker_if.sv
// rs_entry_tracker_if: dispatch-side grant/release bus and tracker status
interface rs_entry_tracker_if #(parameter int p_SIZE = rs_pkg::RS_SIZE);
  localparam int IDX_W = $clog2(p_SIZE);
  localparam int CNT_W = $clog2(p_SIZE + 1);
  logic [p_SIZE-1:0] alloc1_gnt;
  logic [p_SIZE-1:0] alloc2_gnt;
  logic [p_SIZE-1:0] release_vec;
  logic              flush;
  logic [p_SIZE-1:0] free_vec;
  logic [CNT_W-1:0]  busy_count;
  logic              full;
  logic              almost_full;
  logic              alloc1_valid;
  logic              alloc2_valid;
  logic [IDX_W-1:0]  alloc1_idx;
  logic [IDX_W-1:0]  alloc2_idx;
  logic              err;
  modport master (
    output alloc1_gnt, alloc2_gnt, release_vec, flush,
    input  free_vec, busy_count, full, almost_full,
           alloc1_valid, alloc2_valid, alloc1_idx, alloc2_idx, err
  );
  modport slave (
    input  alloc1_gnt, alloc2_gnt, release_vec, flush,
    output free_vec, busy_count, full, almost_full,
           alloc1_valid, alloc2_valid, alloc1_idx, alloc2_idx, err
  );
endinterface

// File: rtl/onehot_encoder.sv
// onehot_encoder: one-hot to binary index, with any-bit and multi-bit flags
module onehot_encoder #(
  parameter int p_SIZE = 8,
  localparam int IDX_W = $clog2(p_SIZE)
) (
  input  logic [p_SIZE-1:0] vec,
  output logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              multi
);
  logic seen;
  always_comb begin
    idx   = '0;
    multi = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < p_SIZE; i++) begin
      if (vec[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = idx | IDX_W'(i);
      end
    end
    valid = seen;
  end
endmodule

// File: rtl/rs_entry_tracker.sv
// rs_entry_tracker: busy/free occupancy of the reservation station, grant
// acceptance with encoded indices, release/flush and dispatch stall flags
module rs_entry_tracker
  import rs_pkg::*;
#(
  parameter int p_SIZE = RS_SIZE,
  localparam int IDX_W = $clog2(p_SIZE),
  localparam int CNT_W = $clog2(p_SIZE + 1)
) (
  input logic               clock,
  input logic               reset,
  rs_entry_tracker_if.slave bus
);
  logic [p_SIZE-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              v1_q, v1_d, v2_q, v2_d, err_q, err_d;
  logic [IDX_W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic [IDX_W-1:0]  e1_idx, e2_idx;
  logic              e1_any, e1_multi, e2_any, e2_multi;
  logic              legal1, legal2, overlap, bad;
  logic [p_SIZE-1:0] g1, g2;
  onehot_encoder #(.p_SIZE(p_SIZE)) u_enc1 (
    .vec(bus.alloc1_gnt), .idx(e1_idx), .valid(e1_any), .multi(e1_multi)
  );
  onehot_encoder #(.p_SIZE(p_SIZE)) u_enc2 (
    .vec(bus.alloc2_gnt), .idx(e2_idx), .valid(e2_any), .multi(e2_multi)
  );
  // Legality is judged against the registered busy set only; a release in
  // this cycle never frees an entry for a grant in the same cycle.
  always_comb begin
    overlap = |(bus.alloc1_gnt & bus.alloc2_gnt);
    legal1  = e1_any & ~e1_multi & ~|(bus.alloc1_gnt & busy_q);
    legal2  = e2_any & ~e2_multi & ~|(bus.alloc2_gnt & busy_q) & ~overlap;
    g1      = legal1 ? bus.alloc1_gnt : '0;
    g2      = legal2 ? bus.alloc2_gnt : '0;
    bad     = e1_multi | e2_multi | overlap | |(bus.alloc1_gnt & busy_q)
            | |(bus.alloc2_gnt & busy_q) | |(bus.release_vec & ~busy_q);
    busy_d  = bus.flush ? '0 : (busy_q & ~bus.release_vec) | g1 | g2;
    count_d = bus.flush ? '0
            : count_q + popcount(g1 | g2) - popcount(bus.release_vec & busy_q);
    v1_d    = ~bus.flush & legal1;
    v2_d    = ~bus.flush & legal2;
    i1_d    = v1_d ? e1_idx : i1_q;
    i2_d    = v2_d ? e2_idx : i2_q;
    err_d   = err_q | (~bus.flush & bad);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      i1_q    <= '0;
      i2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      err_q   <= err_d;
    end
  end
  assign bus.free_vec     = ~busy_q;
  assign bus.busy_count   = count_q;
  assign bus.full         = count_q == CNT_W'(p_SIZE);
  assign bus.almost_full  = count_q >= CNT_W'(p_SIZE - 1);
  assign bus.alloc1_valid = v1_q;
  assign bus.alloc2_valid = v2_q;
  assign bus.alloc1_idx   = i1_q;
  assign bus.alloc2_idx   = i2_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_rs_entry_tracker.sv
// tb_rs_entry_tracker: directed vector table plus short hand sequences
module tb_rs_entry_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  rs_entry_tracker_if #(.p_SIZE(8)) bus ();
  rs_entry_tracker #(.p_SIZE(8)) dut (.clock(clk), .reset(rst), .bus(bus.slave));
  typedef struct {
    logic       rst;
    logic [7:0] a1, a2, rel;
    logic       fl;
    logic [7:0] free;
    logic [3:0] cnt;
    logic       full, af, v1, v2;
    logic [2:0] i1, i2;
    logic       err;
  } vec_t;
  vec_t vecs[25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pc(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction
  task automatic drive(input logic r, input logic [7:0] a1, input logic [7:0] a2,
                       input logic [7:0] rel, input logic fl);
    rst = r;
    bus.alloc1_gnt = a1;
    bus.alloc2_gnt = a2;
    bus.release_vec = rel;
    bus.flush = fl;
    @(posedge clk);
    #1;
    chk("count_vs_free", 32'(bus.busy_count), 32'(pc(~bus.free_vec)));
  endtask
  initial begin
    bus.alloc1_gnt = '0;
    bus.alloc2_gnt = '0;
    bus.release_vec = '0;
    bus.flush = 1'b0;
    //            rst a1     a2     rel    fl  free   cnt full af v1 v2 i1 i2 err
    vecs[0]  = '{1, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 8'h01, 8'h02, 8'h00, 0, 8'hFC, 2, 0, 0, 1, 1, 0, 1, 0};
    vecs[2]  = '{0, 8'h04, 8'h08, 8'h00, 0, 8'hF0, 4, 0, 0, 1, 1, 2, 3, 0};
    vecs[3]  = '{0, 8'h10, 8'h20, 8'h00, 0, 8'hC0, 6, 0, 0, 1, 1, 4, 5, 0};
    vecs[4]  = '{0, 8'h40, 8'h00, 8'h00, 0, 8'h80, 7, 0, 1, 1, 0, 6, 5, 0};
    vecs[5]  = '{0, 8'h00, 8'h80, 8'h00, 0, 8'h00, 8, 1, 1, 0, 1, 6, 7, 0};
    vecs[6]  = '{0, 8'h80, 8'h00, 8'h81, 0, 8'h81, 6, 0, 0, 0, 0, 6, 7, 1};
    vecs[7]  = '{0, 8'h00, 8'h00, 8'h00, 0, 8'h81, 6, 0, 0, 0, 0, 6, 7, 1};
    vecs[8]  = '{0, 8'h01, 8'h80, 8'h00, 0, 8'h00, 8, 1, 1, 1, 1, 0, 7, 1};
    vecs[9]  = '{1, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 8'h03, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{0, 8'h00, 8'h04, 8'h00, 0, 8'hFB, 1, 0, 0, 0, 1, 0, 2, 1};
    vecs[12] = '{0, 8'h04, 8'h08, 8'h00, 0, 8'hF3, 2, 0, 0, 0, 1, 0, 3, 1};
    vecs[13] = '{1, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 8'h10, 8'h10, 8'h00, 0, 8'hEF, 1, 0, 0, 1, 0, 4, 0, 1};
    vecs[15] = '{0, 8'h00, 8'h00, 8'h20, 0, 8'hEF, 1, 0, 0, 0, 0, 4, 0, 1};
    vecs[16] = '{0, 8'h00, 8'h00, 8'h10, 0, 8'hFF, 0, 0, 0, 0, 0, 4, 0, 1};
    vecs[17] = '{1, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[18] = '{0, 8'h01, 8'h02, 8'h00, 0, 8'hFC, 2, 0, 0, 1, 1, 0, 1, 0};
    vecs[19] = '{0, 8'h04, 8'h08, 8'h00, 0, 8'hF0, 4, 0, 0, 1, 1, 2, 3, 0};
    vecs[20] = '{0, 8'h10, 8'h20, 8'h00, 0, 8'hC0, 6, 0, 0, 1, 1, 4, 5, 0};
    vecs[21] = '{0, 8'h40, 8'h80, 8'h00, 0, 8'h00, 8, 1, 1, 1, 1, 6, 7, 0};
    vecs[22] = '{0, 8'h00, 8'h10, 8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, 6, 7, 0};
    vecs[23] = '{1, 8'h01, 8'h02, 8'hFF, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[24] = '{0, 8'h02, 8'h01, 8'h00, 0, 8'hFC, 2, 0, 0, 1, 1, 1, 0, 0};
    for (int k = 0; k < 25; k++) begin
      drive(vecs[k].rst, vecs[k].a1, vecs[k].a2, vecs[k].rel, vecs[k].fl);
      chk($sformatf("v%0d_free", k), 32'(bus.free_vec), 32'(vecs[k].free));
      chk($sformatf("v%0d_cnt", k), 32'(bus.busy_count), 32'(vecs[k].cnt));
      chk($sformatf("v%0d_full", k), 32'(bus.full), 32'(vecs[k].full));
      chk($sformatf("v%0d_af", k), 32'(bus.almost_full), 32'(vecs[k].af));
      chk($sformatf("v%0d_v1", k), 32'(bus.alloc1_valid), 32'(vecs[k].v1));
      chk($sformatf("v%0d_v2", k), 32'(bus.alloc2_valid), 32'(vecs[k].v2));
      chk($sformatf("v%0d_i1", k), 32'(bus.alloc1_idx), 32'(vecs[k].i1));
      chk($sformatf("v%0d_i2", k), 32'(bus.alloc2_idx), 32'(vecs[k].i2));
      chk($sformatf("v%0d_err", k), 32'(bus.err), 32'(vecs[k].err));
    end
    // Fill at full rate, bulk release, then confirm no same-cycle reuse.
    drive(1, 8'h00, 8'h00, 8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h01 << (2 * k), 8'h02 << (2 * k), 8'h00, 0);
      chk("fill_cnt", 32'(bus.busy_count), 32'(2 * (k + 1)));
      chk("fill_i2", 32'(bus.alloc2_idx), 32'(2 * k + 1));
    end
    drive(0, 8'h01, 8'h00, 8'hFF, 0);
    chk("bulk_rel_free", 32'(bus.free_vec), 32'hFF);
    chk("bulk_rel_v1", 32'(bus.alloc1_valid), 32'd0);
    chk("bulk_rel_err", 32'(bus.err), 32'd1);
    drive(0, 8'h01, 8'h00, 8'h00, 0);
    chk("regrant_free", 32'(bus.free_vec), 32'hFE);
    chk("regrant_v1", 32'(bus.alloc1_valid), 32'd1);
    chk("regrant_i1", 32'(bus.alloc1_idx), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_entry_tracker.md
# rs_entry_tracker

Occupancy tracker for an 8-entry reservation-station table in the 2-way dispatch path. It holds the busy bit of every entry and drives the free vector that the dual priority selector consumes as `available`. Each cycle it takes back the selector's two one-hot load grants, marks those entries busy and returns their encoded indices. It also frees entries on issue/completion release and on pipeline flush, and raises the dispatch stall signals.

## Interface
- `p_SIZE`, 8, number of tracked entries (≥2)
- `IDX_W`, $clog2(p_SIZE), localparam, encoded index width
- `CNT_W`, $clog2(p_SIZE+1), localparam, occupancy count width

- `clock` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `alloc1_gnt` in p_SIZE: first-slot load grant, one-hot or zero
- `alloc2_gnt` in p_SIZE: second-slot load grant, one-hot or zero
- `release` in p_SIZE: multi-hot, entries freed this cycle (issue/retire)
- `flush` in 1: free every entry
- `free_vec` out p_SIZE: registered ~busy, feeds selector `available`
- `busy_count` out CNT_W: number of busy entries
- `full` out 1: busy_count == p_SIZE
- `almost_full` out 1: free entries < 2; 2-way dispatch stalls
- `alloc1_valid`, `alloc2_valid` out 1: registered, grant accepted last cycle
- `alloc1_idx`, `alloc2_idx` out IDX_W: registered binary index of the accepted grant
- `err` out 1: sticky protocol-violation flag

## Operation
- State: `busy[p_SIZE]`, `busy_count`, index/valid output registers, `err`.
- Next busy = (busy & ~release) | alloc1_gnt | alloc2_gnt. `flush` overrides and gives next busy = 0, with alloc and release ignored.
- `busy_count` is maintained incrementally: +popcount(alloc legal grants) − popcount(release & busy). It must always equal popcount(busy), and the bench checks this every cycle.
- Grants are only legal on entries free in the *current registered* `free_vec`. Release has no bypass: an entry released in cycle N can be granted no earlier than N+1.
- `err` sets on any of the following, and the offending bit is ignored (state not corrupted):
  - a grant on a busy entry
  - a grant that is not one-hot/zero
  - alloc1_gnt & alloc2_gnt ≠ 0
  - a release of a free entry
- `err` is cleared only by `reset`.
- Grant and release on the same entry in the same cycle: the entry is busy, so the grant is illegal. The entry ends free and `err` is set.
- `alloc*_valid` = |alloc*_gnt of a legal grant. `alloc*_idx` = encoded position; it holds its previous value when valid is 0.
- On flush cycle: `alloc*_valid` deasserts next cycle.

## Timing
- Reset values: busy = 0, `free_vec` = all ones, `busy_count` = 0, `full` = 0, `almost_full` = 0 (p_SIZE ≥ 2), `alloc*_valid` = 0, `alloc*_idx` = 0, `err` = 0.
- Grant in cycle N: `free_vec` bit clears, `busy_count` updates and `alloc*_valid/idx` are presented at N+1. Latency is 1, with no combinational input-to-output path.
- `full` and `almost_full` are decoded from the registered count, so they are valid in the same cycle as `free_vec`.
- Reset mid-operation dominates flush, alloc and release. The next cycle shows reset values.
- Back-to-back full rate: two grants every cycle are sustained while free ≥ 2.

## Structure
- Shared package (`rs_pkg`): `RS_SIZE = 8`, `RS_IDX_W`, `RS_CNT_W`, and the popcount function.
- One sub-module: `onehot_encoder` (p_SIZE one-hot → IDX_W index plus `valid` and `multi` flags), instantiated twice.

## Test plan
- Reset, then alloc1_gnt = 8'h01, alloc2_gnt = 8'h02 -> next cycle free_vec = 8'hFC, busy_count = 2, idx 0/1, both valid, err = 0.
- Fill all 8 entries over 4 cycles with two grants per cycle -> almost_full after 7 busy, full = 1 at busy_count = 8, free_vec = 8'h00.
- From full, release = 8'h81 -> next cycle free_vec = 8'h81, busy_count = 6, almost_full = 0. Granting 8'h80 in the release cycle sets err and leaves bit 7 free.
- Grant 8'h03 on alloc1 (not one-hot) -> err = 1, no state change. err stays 1 until reset.
- busy = 8'hFF, flush with alloc2_gnt = 8'h10 -> next cycle free_vec = 8'hFF, busy_count = 0, alloc2_valid = 0.
- Reset asserted with alloc and release active -> all outputs at reset values the next cycle.
